// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and widths for the LC-3 memory responder
package lc3_pkg;
    typedef enum logic [1:0] {MR_IDLE, MR_WAIT, MR_RESP} mem_state_t;
    localparam int LC3_WORD_W = 16;
endpackage

// File: rtl/lc3_sram_array.sv
// lc3_sram_array: single-port synchronous RAM, read-first with registered read data
module lc3_sram_array
    import lc3_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                  CLK,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [LC3_WORD_W-1:0] wdata,
    output logic [LC3_WORD_W-1:0] rdata
);
    logic [LC3_WORD_W-1:0] mem [2**ADDR_W];

    // Read the old word on every enabled cycle; commit the write on the same edge
    always_ff @(posedge CLK) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: CS/WE/READY memory responder with programmable wait states
module lc3_mem_responder
    import lc3_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  CS,
    input  logic                  WE,
    input  logic [15:0]           ADDR,
    input  logic [15:0]           WDATA,
    output logic                  READY,
    output logic [LC3_WORD_W-1:0] RDATA,
    output logic                  BUSY
);
    localparam logic [3:0] CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    mem_state_t            state, state_nx;
    logic [3:0]            cnt;
    logic [ADDR_W-1:0]     addr_q, ram_addr;
    logic                  we_q, ram_en, ram_we;
    logic [LC3_WORD_W-1:0] wdata_q, rdata_hold, ram_rdata;

    lc3_sram_array #(.ADDR_W(ADDR_W)) u_ram (
        .CLK   (CLK),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Next state and RAM strobes: reads fire on the edge entering RESP, writes on the edge leaving it
    always_comb begin
        state_nx = state;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = addr_q;
        case (state)
            MR_IDLE: if (CS) begin
                state_nx = (LATENCY == 0) ? MR_RESP : MR_WAIT;
                ram_addr = ADDR[ADDR_W-1:0];
                ram_en   = (LATENCY == 0) && !WE;
            end
            MR_WAIT: if (!CS) state_nx = MR_IDLE;
                     else if (cnt == 4'd0) begin
                         state_nx = MR_RESP;
                         ram_en   = !we_q;
                     end
            MR_RESP: begin
                state_nx = MR_IDLE;
                ram_en   = we_q;
                ram_we   = we_q;
            end
            default: state_nx = MR_IDLE;
        endcase
    end

    // State, wait counter, request latches and the held read result
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= MR_IDLE;
            cnt        <= 4'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_hold <= '0;
        end else begin
            state <= state_nx;
            if (state == MR_IDLE && CS) begin
                addr_q  <= ADDR[ADDR_W-1:0];
                we_q    <= WE;
                wdata_q <= WDATA;
                cnt     <= CNT_LOAD;
            end else if (state == MR_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == MR_RESP && !we_q) rdata_hold <= ram_rdata;
        end
    end

    assign READY = (state == MR_RESP);
    assign BUSY  = (state != MR_IDLE);
    assign RDATA = (READY && !we_q) ? ram_rdata : rdata_hold;
endmodule
